// File: rtl/irq_request_latch_pkg.sv
// ---------------------------------------------------------------------------
// pic_irq_pkg
// Shared types and constants for the PIC interrupt request register.
//   trig_mode_e : trigger mode of the request lines (edge or level)
//   MAX_IRQ     : largest number of request channels the block supports
//   irq_id_w(n) : width of a channel ID able to address n channels
// ---------------------------------------------------------------------------
package pic_irq_pkg;

  typedef enum logic {
    TRIG_EDGE  = 1'b0,
    TRIG_LEVEL = 1'b1
  } trig_mode_e;

  localparam int MAX_IRQ = 32;

  function automatic int irq_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_request_latch_if.sv
// ---------------------------------------------------------------------------
// irq_request_latch_if
// Acknowledge and read-back channel between the priority resolver / data
// buffer (master) and the interrupt request register (slave).
//   ackValid  : master -> slave, acknowledge one channel this cycle
//   ackId     : master -> slave, channel to clear (out-of-range IDs ignored)
//   readIRR   : master -> slave, request a registered read-back of IRR
//   readData  : slave -> master, IRR snapshot from the readIRR cycle
//   readValid : slave -> master, readData valid for one cycle
// ---------------------------------------------------------------------------
interface irq_request_latch_if
  import pic_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = irq_id_w(NUM_IRQ)
);

  logic               ackValid;
  logic [ID_W-1:0]    ackId;
  logic               readIRR;
  logic [NUM_IRQ-1:0] readData;
  logic               readValid;

  modport master (
    output ackValid, ackId, readIRR,
    input  readData, readValid
  );

  modport slave (
    input  ackValid, ackId, readIRR,
    output readData, readValid
  );

endinterface

// File: rtl/irq_request_latch_cell.sv
// ---------------------------------------------------------------------------
// irq_channel_cell
// One interrupt request channel: previous-line flop for edge detection,
// edge-hold flop that buffers edges seen during freeze, and the IRR bit.
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   irS_i        : request line, already in the clk domain
//   levelMode_i  : edge or level triggering
//   freeze_i     : blocks new sets into the IRR bit
//   ack_i        : clear this channel's IRR bit
//   irrQ_o       : IRR bit
// ---------------------------------------------------------------------------
module irq_channel_cell
  import pic_irq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irS_i,
  input  trig_mode_e levelMode_i,
  input  logic       freeze_i,
  input  logic       ack_i,
  output logic       irrQ_o
);

  logic prevIr_q, prevIr_d;
  logic edgeHold_q, edgeHold_d;
  logic irr_q, irr_d;
  logic rise;

  assign rise = irS_i & ~prevIr_q;

  // Next-state logic. A set is ORed in after the ack clear, so a rise and an
  // ack in the same unfrozen cycle leave the bit set and no request is lost.
  always_comb begin
    prevIr_d   = irS_i;
    edgeHold_d = edgeHold_q;
    irr_d      = irr_q;
    if (levelMode_i == TRIG_LEVEL) begin
      edgeHold_d = 1'b0;
      irr_d      = freeze_i ? (irr_q & ~ack_i) : (irS_i & ~ack_i);
    end else if (freeze_i) begin
      irr_d      = irr_q & ~ack_i;
      edgeHold_d = edgeHold_q | rise;
    end else begin
      irr_d      = (irr_q & ~ack_i) | rise | edgeHold_q;
      edgeHold_d = 1'b0;
    end
  end

  // prevIr resets low, so a line already high at reset release counts as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prevIr_q   <= 1'b0;
      edgeHold_q <= 1'b0;
      irr_q      <= 1'b0;
    end else begin
      prevIr_q   <= prevIr_d;
      edgeHold_q <= edgeHold_d;
      irr_q      <= irr_d;
    end
  end

  assign irrQ_o = irr_q;

endmodule

// File: rtl/irq_request_latch.sv
// ---------------------------------------------------------------------------
// irq_request_latch
// Clocked interrupt request register for the PIC. Latches NUM_IRQ request
// lines in edge or level mode, holds them until acknowledged, buffers edges
// during an INTA freeze and offers masked pending bits plus a registered
// read-back of IRR.
// Compile option: IRQ_SYNC_EN adds a 2-flop synchroniser per request line
// (2 extra cycles latency); without it irIn must be in the clk domain.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   irIn       : raw request lines, bit i is IRi
//   levelMode  : 0 = edge, 1 = level triggered
//   bitToMask  : IMR, 1 = channel masked
//   freeze     : INTA window, blocks new sets into IRR
//   bus        : ack / read-back interface (slave side)
//   irrQ       : raw IRR contents
//   risedBits  : irrQ & ~bitToMask
//   anyPending : OR of risedBits
// ---------------------------------------------------------------------------
module irq_request_latch
  import pic_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = irq_id_w(NUM_IRQ)
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irIn,
  input  logic                levelMode,
  input  logic [NUM_IRQ-1:0]  bitToMask,
  input  logic                freeze,
  irq_request_latch_if.slave  bus,
  output logic [NUM_IRQ-1:0]  irrQ,
  output logic [NUM_IRQ-1:0]  risedBits,
  output logic                anyPending
);

  if (NUM_IRQ < 2 || NUM_IRQ > MAX_IRQ) begin : gBadNumIrq
    $error("irq_request_latch: NUM_IRQ out of range");
  end

  logic [NUM_IRQ-1:0] irS;
  logic [NUM_IRQ-1:0] ackVec;
  logic [ID_W-1:0]    ackId;
  logic [NUM_IRQ-1:0] readData_q, readData_d;
  logic               readValid_q, readValid_d;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser in front of the edge/level logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irIn;
      sync2_q <= sync1_q;
    end
  end

  assign irS = sync2_q;
`else
  assign irS = irIn;
`endif

  assign ackId = bus.ackId;

  // One-hot ack decode; IDs at or above NUM_IRQ match no channel.
  always_comb begin
    ackVec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ackVec[i] = bus.ackValid && (32'(ackId) == 32'(i));
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : gChan
    irq_channel_cell uCell (
      .clk         (clk),
      .rst_n       (rst_n),
      .irS_i       (irS[g]),
      .levelMode_i (trig_mode_e'(levelMode)),
      .freeze_i    (freeze),
      .ack_i       (ackVec[g]),
      .irrQ_o      (irrQ[g])
    );
  end

  // Read-back samples irrQ before this cycle's update lands.
  always_comb begin
    readData_d  = readData_q;
    readValid_d = bus.readIRR;
    if (bus.readIRR) begin
      readData_d = irrQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readData_q  <= '0;
      readValid_q <= 1'b0;
    end else begin
      readData_q  <= readData_d;
      readValid_q <= readValid_d;
    end
  end

  assign bus.readData  = readData_q;
  assign bus.readValid = readValid_q;
  assign risedBits     = irrQ & ~bitToMask;
  assign anyPending    = |risedBits;

endmodule

// File: tb/tb_irq_request_latch.sv
// ---------------------------------------------------------------------------
// tb_irq_request_latch
// Self-checking bench for irq_request_latch with NUM_IRQ=8 and a 4-bit ack
// ID so that out-of-range IDs can be driven. A directed cycle table covers
// the named corner cases, then a randomized run is compared against a
// word-level reference model.
// ---------------------------------------------------------------------------
module tb_irq_request_latch;

  localparam int N  = 8;
  localparam int IW = 4;

  typedef struct {
    logic         rstN;
    logic [N-1:0] ir;
    logic         lvl;
    logic [N-1:0] mask;
    logic         frz;
    logic         ackV;
    logic [IW-1:0] ackId;
    logic         rd;
    logic [N-1:0] expIrr;
    logic [N-1:0] expRdData;
    logic         expRdValid;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irIn;
  logic         levelMode;
  logic [N-1:0] bitToMask;
  logic         freeze;
  logic [N-1:0] irrQ;
  logic [N-1:0] risedBits;
  logic         anyPending;

  int nVec;
  int nFail;

  // Reference model state, kept as whole words.
  logic [N-1:0] mIrr, mPrev, mHold, mRd, mS1, mS2;
  logic         mRv;

  irq_request_latch_if #(.NUM_IRQ(N), .ID_W(IW)) busIf ();

  irq_request_latch #(.NUM_IRQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irIn       (irIn),
    .levelMode  (levelMode),
    .bitToMask  (bitToMask),
    .freeze     (freeze),
    .bus        (busIf),
    .irrQ       (irrQ),
    .risedBits  (risedBits),
    .anyPending (anyPending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic rstN, logic [N-1:0] ir, logic lvl,
                                 logic [N-1:0] mask, logic frz, logic ackV,
                                 logic [IW-1:0] ackId, logic rd,
                                 logic [N-1:0] expIrr, logic [N-1:0] expRdData,
                                 logic expRdValid);
    vec_t v;
    v.rstN = rstN; v.ir = ir; v.lvl = lvl; v.mask = mask; v.frz = frz;
    v.ackV = ackV; v.ackId = ackId; v.rd = rd; v.expIrr = expIrr;
    v.expRdData = expRdData; v.expRdValid = expRdValid;
    return v;
  endfunction

  // Drives one cycle's inputs on the falling edge.
  task automatic applyStimulus(input logic rstN, input logic [N-1:0] ir,
                               input logic lvl, input logic [N-1:0] mask,
                               input logic frz, input logic ackV,
                               input logic [IW-1:0] ackId, input logic rd);
    @(negedge clk);
    rst_n           = rstN;
    irIn            = ir;
    levelMode       = lvl;
    bitToMask       = mask;
    freeze          = frz;
    busIf.ackValid  = ackV;
    busIf.ackId     = ackId;
    busIf.readIRR   = rd;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act,
                             input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [N-1:0] eIrr,
                          input logic [N-1:0] mask, input logic [N-1:0] eRd,
                          input logic eRv);
    logic [N-1:0] eRise;
    eRise = eIrr & ~mask;
    checkOutput({tag, " irrQ"},       32'(irrQ),            32'(eIrr));
    checkOutput({tag, " risedBits"},  32'(risedBits),       32'(eRise));
    checkOutput({tag, " anyPending"}, 32'(anyPending),      32'(eRise != '0));
    checkOutput({tag, " readData"},   32'(busIf.readData),  32'(eRd));
    checkOutput({tag, " readValid"},  32'(busIf.readValid), 32'(eRv));
  endtask

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic modelStep();
    logic [N-1:0] s, rise, ackM;
    int id;
`ifdef IRQ_SYNC_EN
    s = mS2;
`else
    s = irIn;
`endif
    id   = int'(busIf.ackId);
    ackM = (busIf.ackValid && id < N) ? N'(1 << id) : '0;
    rise = s & ~mPrev;
    if (!rst_n) begin
      mIrr = '0; mPrev = '0; mHold = '0; mRd = '0; mRv = 1'b0;
      mS1 = '0; mS2 = '0;
    end else begin
      mRv = busIf.readIRR;
      if (busIf.readIRR) mRd = mIrr;
      if (levelMode) begin
        mIrr  = freeze ? (mIrr & ~ackM) : (s & ~ackM);
        mHold = '0;
      end else if (freeze) begin
        mIrr  = mIrr & ~ackM;
        mHold = mHold | rise;
      end else begin
        mIrr  = (mIrr & ~ackM) | rise | mHold;
        mHold = '0;
      end
      mPrev = s;
      mS2   = mS1;
      mS1   = irIn;
    end
  endtask

  initial begin
    vec_t vecs[35];
    logic [N-1:0] ir;
    logic lvl;

    nVec = 0;
    nFail = 0;
    rst_n = 1'b0; irIn = '0; levelMode = 1'b0; bitToMask = '0; freeze = 1'b0;
    busIf.ackValid = 1'b0; busIf.ackId = '0; busIf.readIRR = 1'b0;

`ifndef IRQ_SYNC_EN
    //                rst  ir     lvl  mask   frz  ackV id    rd   irr    rdData vld
    vecs[0]  = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[1]  = mkVec(1, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[2]  = mkVec(1, 8'h04, 0, 8'h00, 0, 0, 4'd0, 0, 8'h04, 8'h00, 0);
    vecs[3]  = mkVec(1, 8'h04, 0, 8'h00, 0, 0, 4'd0, 0, 8'h04, 8'h00, 0);
    vecs[4]  = mkVec(1, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h04, 8'h00, 0);
    vecs[5]  = mkVec(1, 8'h04, 0, 8'h00, 0, 1, 4'd2, 0, 8'h04, 8'h00, 0);
    vecs[6]  = mkVec(1, 8'h04, 0, 8'h00, 0, 1, 4'd2, 0, 8'h00, 8'h00, 0);
    vecs[7]  = mkVec(1, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[8]  = mkVec(1, 8'h20, 0, 8'h00, 1, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[9]  = mkVec(1, 8'h00, 0, 8'h00, 1, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[10] = mkVec(1, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h20, 8'h00, 0);
    vecs[11] = mkVec(1, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h20, 8'h00, 0);
    vecs[12] = mkVec(1, 8'h00, 0, 8'h00, 0, 1, 4'd5, 0, 8'h00, 8'h00, 0);
    vecs[13] = mkVec(1, 8'h81, 1, 8'h00, 0, 0, 4'd0, 0, 8'h81, 8'h00, 0);
    vecs[14] = mkVec(1, 8'h01, 1, 8'h00, 0, 0, 4'd0, 0, 8'h01, 8'h00, 0);
    vecs[15] = mkVec(1, 8'h01, 1, 8'h00, 0, 1, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[16] = mkVec(1, 8'h01, 1, 8'h00, 0, 0, 4'd0, 0, 8'h01, 8'h00, 0);
    vecs[17] = mkVec(1, 8'h00, 1, 8'h00, 1, 0, 4'd0, 0, 8'h01, 8'h00, 0);
    vecs[18] = mkVec(1, 8'h00, 1, 8'h00, 1, 1, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[19] = mkVec(1, 8'h00, 1, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[20] = mkVec(1, 8'hFF, 0, 8'h00, 0, 0, 4'd0, 0, 8'hFF, 8'h00, 0);
    vecs[21] = mkVec(1, 8'hFF, 0, 8'hF0, 0, 0, 4'd0, 0, 8'hFF, 8'h00, 0);
    vecs[22] = mkVec(1, 8'hFF, 0, 8'hF0, 0, 0, 4'd0, 1, 8'hFF, 8'hFF, 1);
    vecs[23] = mkVec(1, 8'hFF, 0, 8'hF0, 0, 0, 4'd0, 0, 8'hFF, 8'hFF, 0);
    vecs[24] = mkVec(1, 8'hFF, 0, 8'hF0, 0, 1, 4'd9, 0, 8'hFF, 8'hFF, 0);
    vecs[25] = mkVec(1, 8'hFF, 0, 8'hF0, 0, 1, 4'd0, 1, 8'hFE, 8'hFF, 1);
    vecs[26] = mkVec(1, 8'hFF, 0, 8'h00, 0, 1, 4'd8, 0, 8'hFE, 8'hFF, 0);
    vecs[27] = mkVec(0, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[28] = mkVec(1, 8'h3C, 0, 8'h00, 0, 0, 4'd0, 0, 8'h3C, 8'h00, 0);
    vecs[29] = mkVec(1, 8'h3D, 0, 8'h00, 1, 0, 4'd0, 0, 8'h3C, 8'h00, 0);
    vecs[30] = mkVec(0, 8'h3D, 0, 8'h00, 1, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[31] = mkVec(1, 8'h00, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[32] = mkVec(1, 8'h01, 0, 8'h00, 0, 0, 4'd0, 0, 8'h01, 8'h00, 0);
    vecs[33] = mkVec(0, 8'h01, 0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 8'h00, 0);
    vecs[34] = mkVec(1, 8'h01, 0, 8'h00, 0, 0, 4'd0, 0, 8'h01, 8'h00, 0);

    $display("[TB] directed table");
    for (int i = 0; i < 35; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].ir, vecs[i].lvl, vecs[i].mask,
                    vecs[i].frz, vecs[i].ackV, vecs[i].ackId, vecs[i].rd);
      @(posedge clk);
      #1;
      checkAll($sformatf("row%0d", i), vecs[i].expIrr, vecs[i].mask,
               vecs[i].expRdData, vecs[i].expRdValid);
    end
`else
    $display("[TB] synchroniser latency");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(i < 2 ? 1'b0 : 1'b1, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk);
      #1;
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'h10, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      @(posedge clk);
      #1;
      checkAll($sformatf("sync+%0d", i), (i >= 3) ? 8'h10 : 8'h00, '0, '0, 1'b0);
    end
`endif

    $display("[TB] randomized run against model");
    ir  = '0;
    lvl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, ir, lvl, '0, 1'b0, 1'b0, '0, 1'b0);
      modelStep();
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 400; i++) begin
      ir = ir ^ N'($urandom & $urandom);
      if ($urandom_range(0, 19) == 0) lvl = ~lvl;
      applyStimulus($urandom_range(0, 49) != 0, ir, lvl, N'($urandom),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    IW'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      modelStep();
      @(posedge clk);
      #1;
      checkAll($sformatf("rnd%0d", i), mIrr, bitToMask, mRd, mRv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
